oem8_frame_ctrl: RTL and testbench
==================================

OEM8_FRAME_CTRL -- requirements
Module: oem8_frame_ctrl

Interface
REQ-001 Parameter SORT_WAIT, default 1: cycles spent in SORT before capturing sort_out; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream element valid.
REQ-005 in_ready  output  1  controller accepts in_data this cycle.
REQ-006 in_data  input  6  unsigned element.
REQ-007 in_last  input  1  final element of a short frame (present only with OEM_PARTIAL_FLUSH_EN).
REQ-008 sort_in  output  48  frame to the external 8-input merge sorter; element k in bits [6k+5:6k].
REQ-009 sort_out  input  48  sorter result, ascending; bits [5:0] hold the minimum.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  6  sorted element.
REQ-013 out_last  output  1  final element of the current frame.
REQ-014 busy  output  1  high in any state other than FILL.

Function
REQ-015 The FSM SHALL have three states: FILL, SORT and DRAIN.
REQ-016 FILL: in_ready=1. An accept is in_valid&in_ready; it SHALL write in_data to ibuf[cnt] and increment cnt.
REQ-017 An accept at cnt==7 SHALL move the FSM to SORT with len=8, and in_ready SHALL be 0 from the next cycle.
REQ-018 sort_in SHALL always equal the concatenated ibuf, with no masking by state.
REQ-019 SORT: a wait counter SHALL count SORT_WAIT cycles. On its last cycle, obuf SHALL load sort_out and the FSM SHALL go to DRAIN.
REQ-020 DRAIN: out_valid=1 and out_data=obuf[idx]. idx SHALL advance only when out_valid&out_ready. out_data and out_last SHALL hold stable while out_ready=0.
REQ-021 out_last SHALL equal (idx==len-1). The handshake on that element SHALL clear cnt and idx and return the FSM to FILL.
REQ-022 in_ready=0 and out_valid=0 outside FILL and DRAIN respectively. Input and output phases SHALL never overlap.
REQ-023 Minimum frame period: 8 (fill) + SORT_WAIT + 8 (drain) cycles at full handshake rate.
REQ-024 Duplicate values SHALL be output with their multiplicity preserved; tie order is irrelevant because only values are carried.
REQ-025 cnt is 3 bits and idx is 3 bits; len is 4 bits (range 1..8).

Reset
REQ-026 rst SHALL, from any state and at any point mid-frame, force FILL, clear cnt/idx/wait to 0, set len=8, and clear ibuf and obuf to 0.
REQ-027 Output values during and after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, sort_in=0.
REQ-028 Partially accepted or partially drained frames SHALL be discarded on reset.

Configuration
REQ-029 The macro OEM_PARTIAL_FLUSH_EN SHALL control short-frame support.
REQ-030 With OEM_PARTIAL_FLUSH_EN, the in_last port exists. An accept with in_last=1 at cnt=k (k<=7) SHALL:
- fill ibuf[k+1..7] with PAD_VAL (6'h3F);
- set len=k+1;
- enter SORT.
REQ-031 With OEM_PARTIAL_FLUSH_EN, only len elements SHALL be drained; pads sort to the top and are dropped. Genuine 6'h3F inputs still count within len.
REQ-032 Without OEM_PARTIAL_FLUSH_EN, the in_last port is absent, every frame is 8 elements, and len is constantly 8.

Structure
REQ-033 Package oem_pkg SHALL hold: ELEM_W=6, FRAME_N=8, PAD_VAL=6'h3F, and the state enum {FILL, SORT, DRAIN}.
REQ-034 Sub-module oem_frame_buf (8x6 register file with a write port, a read mux and a parallel load) SHALL be instantiated twice, once as ibuf and once as obuf.
REQ-035 The sorter is instantiated outside this block and is wired to it only through sort_in and sort_out.

Verification
REQ-036 Full frame: input 5,3,7,1,0,63,2,2 with no stalls -> out_data sequence 0,1,2,2,3,5,7,63; out_last on the eighth element; first out_valid 9+SORT_WAIT cycles after the first accept.
REQ-037 Backpressure: out_ready toggled 1,0,0,1 repeatedly -> out_data and out_last held while stalled; no element lost or duplicated.
REQ-038 Reset mid-DRAIN after 3 elements -> next cycle out_valid=0 and in_ready=1. The following frame of eight 9s -> eight 9s out.
REQ-039 Partial flush (macro on): 40,12,33 with in_last on 33 -> output 12,33,40; out_last on 40; no 63 emitted.
REQ-040 Partial flush with a genuine max (macro on): 63,1 with in_last -> output 1,63, len=2.
REQ-041 Upstream gaps: in_valid low for 4 cycles between elements 4 and 5 -> FSM stays in FILL, cnt holds at 4, result correct.

Source files
------------

// File: rtl/oem_pkg.sv
// Shared types and constants for the 8-element frame controller.
// Holds element/frame geometry, the pad value used for short frames,
// the controller state enum and a helper that builds a padded frame.
package oem_pkg;

  localparam int unsigned ELEM_W  = 6;
  localparam int unsigned FRAME_N = 8;
  localparam int unsigned FRAME_W = ELEM_W * FRAME_N;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LEN_W   = 4;

  localparam logic [ELEM_W-1:0] PAD_VAL = 6'h3F;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Keep slots below k, put data in slot k, pad every slot above k.
  function automatic logic [FRAME_W-1:0] pad_frame(
    input logic [FRAME_W-1:0] frame,
    input logic [IDX_W-1:0]   k,
    input logic [ELEM_W-1:0]  data
  );
    logic [FRAME_N-1:0][ELEM_W-1:0] f;
    f = frame;
    for (int unsigned j = 0; j < FRAME_N; j++) begin
      if (j == 32'(k)) begin
        f[j] = data;
      end else if (j > 32'(k)) begin
        f[j] = PAD_VAL;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/oem_frame_buf.sv
// 8 x 6-bit register file used for both the input and output frame buffers.
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears contents)
//   we/waddr/wdata single-element write port
//   ld/ldata      parallel load of the whole frame (wins over we)
//   raddr/rdata   read mux
//   q             whole frame, element k in bits [6k+5:6k]
module oem_frame_buf
  import oem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [ELEM_W-1:0]  wdata,
  input  logic               ld,
  input  logic [FRAME_W-1:0] ldata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [ELEM_W-1:0]  rdata,
  output logic [FRAME_W-1:0] q
);

  logic [FRAME_N-1:0][ELEM_W-1:0] mem;

  // Storage update: reset, whole-frame load, or single write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (ld) begin
      mem <= ldata;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign q     = mem;

endmodule

// File: rtl/oem8_frame_ctrl.sv
// Frame controller around an external 8-input sorter: collects a frame of
// up to 8 elements, waits SORT_WAIT cycles for the sorter, then streams the
// sorted frame out with a valid/ready handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready/in_data   upstream element handshake
//   in_last           short-frame terminator (only with OEM_PARTIAL_FLUSH_EN)
//   sort_in/sort_out  frame to / sorted frame from the external sorter
//   out_valid/out_ready/out_data/out_last  downstream element handshake
//   busy              high whenever not collecting input
// Build option: define OEM_PARTIAL_FLUSH_EN for short-frame support.
module oem8_frame_ctrl
  import oem_pkg::*;
#(
  parameter int unsigned SORT_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ELEM_W-1:0]  in_data,
`ifdef OEM_PARTIAL_FLUSH_EN
  input  logic               in_last,
`endif
  output logic [FRAME_W-1:0] sort_in,
  input  logic [FRAME_W-1:0] sort_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ELEM_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SORT_WAIT - 1);
  localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(FRAME_N);

  state_e state, state_nx;

  logic [IDX_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [WAIT_W-1:0]  wcnt;
  logic [LEN_W-1:0]   len;

  logic               in_last_c;
  logic               accept;
  logic               short_end;
  logic               full_end;
  logic               drain_hs;
  logic               frame_end;
  logic               obuf_ld;
  logic [FRAME_W-1:0] ibuf_q;
  logic [FRAME_W-1:0] ibuf_ldata;
  logic [ELEM_W-1:0]  ibuf_unused_rd;
  logic [FRAME_W-1:0] obuf_unused_q;

`ifdef OEM_PARTIAL_FLUSH_EN
  assign in_last_c = in_last;
`else
  assign in_last_c = 1'b0;
`endif

  assign accept     = in_valid & in_ready;
  assign short_end  = accept & in_last_c;
  assign full_end   = accept & (cnt == IDX_W'(FRAME_N - 1));
  assign drain_hs   = out_valid & out_ready;
  assign frame_end  = drain_hs & out_last;
  assign out_last   = out_valid & (LEN_W'(idx) == (len - LEN_W'(1)));
  assign ibuf_ldata = pad_frame(ibuf_q, cnt, in_data);
  assign sort_in    = ibuf_q;

  // Short-frame terminator loads the padded frame in one shot.
  oem_frame_buf ibuf (
    .clk   (clk),
    .rst   (rst),
    .we    (accept & ~short_end),
    .waddr (cnt),
    .wdata (in_data),
    .ld    (short_end),
    .ldata (ibuf_ldata),
    .raddr (cnt),
    .rdata (ibuf_unused_rd),
    .q     (ibuf_q)
  );

  oem_frame_buf obuf (
    .clk   (clk),
    .rst   (rst),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .ld    (obuf_ld),
    .ldata (sort_out),
    .raddr (idx),
    .rdata (out_data),
    .q     (obuf_unused_q)
  );

  // Next-state logic.
  always_comb begin
    state_nx = state;
    obuf_ld  = 1'b0;
    unique case (state)
      FILL: begin
        if (full_end || short_end) state_nx = SORT;
      end
      SORT: begin
        if (wcnt == WAIT_LAST) begin
          obuf_ld  = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // State register; handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == FILL);
      out_valid <= (state_nx == DRAIN);
      busy      <= (state_nx != FILL);
    end
  end

  // Fill/drain pointers and sorter wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      wcnt <= '0;
    end else begin
      if (accept) cnt <= cnt + IDX_W'(1);
      if (state == SORT) wcnt <= (wcnt == WAIT_LAST) ? '0 : wcnt + WAIT_W'(1);
      if (drain_hs) idx <= idx + IDX_W'(1);
      if (frame_end) begin
        cnt <= '0;
        idx <= '0;
      end
    end
  end

`ifdef OEM_PARTIAL_FLUSH_EN
  // Frame length: set by the terminating accept, back to full after drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      len <= FULL_LEN;
    end else if (short_end) begin
      len <= LEN_W'(cnt) + LEN_W'(1);
    end else if (full_end || frame_end) begin
      len <= FULL_LEN;
    end
  end
`else
  assign len = FULL_LEN;
`endif

endmodule

// File: tb/tb_oem8_frame_ctrl.sv
// Self-checking bench for oem8_frame_ctrl with a behavioural sorter stand-in,
// a frame-level reference model (sorted value list) and a scoreboard monitor.
// Short-frame scenarios are built only when OEM_PARTIAL_FLUSH_EN is defined.
module tb_oem8_frame_ctrl;

  localparam int SW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_data;
`ifdef OEM_PARTIAL_FLUSH_EN
  logic        in_last;
  bit          mark_last = 1'b0;
`endif
  logic [47:0] sort_in;
  logic [47:0] sort_out;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_data;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int rdy_mode = 0;
  int ph       = 0;

  logic [6:0] sb[$];
  logic [6:0] e;
  bit         stall_q = 1'b0;
  logic [5:0] hold_d;
  logic       hold_l;

  oem8_frame_ctrl #(.SORT_WAIT(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef OEM_PARTIAL_FLUSH_EN
    .in_last   (in_last),
`endif
    .sort_in   (sort_in),
    .sort_out  (sort_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the external sorter: ascending, combinational.
  function automatic logic [47:0] sort8(input logic [47:0] f);
    logic [5:0]  v [8];
    logic [5:0]  t;
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) v[i] = f[6*i +: 6];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[6*i +: 6] = v[i];
    return r;
  endfunction

  always_comb sort_out = sort8(sort_in);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Downstream ready pattern generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: protocol checks, stall hold checks, scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      check("busy_vs_in_ready", busy, !in_ready);
      check("phase_overlap", in_ready & out_valid, 0);
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_last", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_out: got %0d with nothing expected", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e[5:0]);
          check("out_last", out_last, e[6]);
          hs_cnt++;
        end
      end
      stall_q = out_valid && !out_ready;
      hold_d  = out_data;
      hold_l  = out_last;
    end
  end

  // Present one element at posedge+1 phase; returns the accept cycle.
  task automatic drive_elem(input int d, output int acc);
    int g = 0;
    in_valid = 1'b1;
    in_data  = 6'(d);
    @(negedge clk);
    while (!in_ready && g < 1000) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready 0, wanted 1");
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  // Reference model: a frame comes back as its values in ascending order.
  task automatic push_expected(input int vals[$]);
    int s[$];
    s = vals;
    s.sort();
    foreach (s[i]) sb.push_back({(i == s.size() - 1), 6'(s[i])});
  endtask

  task automatic send_frame(input int vals[$], input bit rnd_gaps, output int first_acc);
    int acc;
    push_expected(vals);
    first_acc = 0;
    foreach (vals[i]) begin
      if (rnd_gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
`ifdef OEM_PARTIAL_FLUSH_EN
      in_last = mark_last && (i == vals.size() - 1);
`endif
      drive_elem(vals[i], acc);
      if (i == 0) first_acc = acc;
    end
`ifdef OEM_PARTIAL_FLUSH_EN
    in_last = 1'b0;
`endif
  endtask

  task automatic wait_drain();
    int g = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && g < 3000) begin @(negedge clk); g++; end
    check("drain_done", (sb.size() == 0 && !busy) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_sort_in"}, sort_in, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vals[$];
    int fa, acc, g, base, n;
    logic [47:0] e_si;

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
`ifdef OEM_PARTIAL_FLUSH_EN
    in_last = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed full frame and first-output latency.
    vals = '{5, 3, 7, 1, 0, 63, 2, 2};
    send_frame(vals, 1'b0, fa);
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    // out_valid appears in cycle 9+SW counting the first accept cycle as 1.
    check("first_valid_latency", 64'(cyc - fa), 64'(9 + SW - 2));
    wait_drain();

    // Backpressure 1,0,0,1.
    rdy_mode = 1;
    for (int f = 0; f < 2; f++) begin
      vals = {};
      for (int i = 0; i < 8; i++) vals.push_back($urandom_range(0, 63));
      send_frame(vals, 1'b0, fa);
    end
    wait_drain();
    rdy_mode = 0;

    // Reset in the middle of the drain.
    vals = '{11, 22, 33, 44, 55, 6, 17, 28};
    send_frame(vals, 1'b0, fa);
    base = hs_cnt; g = 0;
    do begin @(posedge clk); g++; end while (hs_cnt < base + 3 && g < 200);
    check("three_drained", (hs_cnt >= base + 3) ? 1 : 0, 1);
    #1;
    rst = 1'b1; rdy_mode = 3;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; rdy_mode = 0;
    @(negedge clk);
    check_reset_state("mid_drain_reset");
    @(posedge clk); #1;
    vals = '{9, 9, 9, 9, 9, 9, 9, 9};
    send_frame(vals, 1'b0, fa);
    wait_drain();

    // Upstream gap of 4 cycles after the 4th element.
    vals = '{20, 50, 10, 30, 44, 1, 60, 7};
    push_expected(vals);
    for (int i = 0; i < 4; i++) drive_elem(vals[i], acc);
    e_si = '0;
    for (int k = 0; k < 8; k++) e_si[6*k +: 6] = (k < 4) ? 6'(vals[k]) : 6'd9;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("gap_in_ready", in_ready, 1);
      check("gap_sort_in", sort_in, e_si);
    end
    @(posedge clk); #1;
    for (int i = 4; i < 8; i++) drive_elem(vals[i], acc);
    wait_drain();

`ifdef OEM_PARTIAL_FLUSH_EN
    // Short frames, including a genuine maximum value.
    mark_last = 1'b1;
    vals = '{40, 12, 33};
    send_frame(vals, 1'b0, fa);
    wait_drain();
    vals = '{63, 1};
    send_frame(vals, 1'b0, fa);
    wait_drain();
    vals = '{17};
    send_frame(vals, 1'b0, fa);
    wait_drain();
    mark_last = 1'b0;
`endif

    // Randomized frames with gaps and random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 16; f++) begin
      n = 8;
`ifdef OEM_PARTIAL_FLUSH_EN
      mark_last = ($urandom_range(0, 1) == 1);
      if (mark_last) n = $urandom_range(1, 8);
`endif
      vals = {};
      for (int i = 0; i < n; i++)
        vals.push_back((f % 2 == 1) ? $urandom_range(60, 63) : $urandom_range(0, 63));
      send_frame(vals, 1'b1, fa);
    end
    wait_drain();
    rdy_mode = 0;
`ifdef OEM_PARTIAL_FLUSH_EN
    mark_last = 1'b0;
`endif

    @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    check("final_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
